// File: rtl/pipelined_adder.sv
// pipelined_adder: ripple-carry adder cut into STAGES register slices,
// with a valid/ready handshake on both sides and signed overflow out.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SLICE = WIDTH / STAGES;

  if (WIDTH < 2) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be at least 2");
  end
  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } stage_t;

  stage_t            st_q  [STAGES];
  stage_t            st_d  [STAGES];
  stage_t            src   [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] src_v;
  logic [STAGES:0]   lv;

  logic [1:0] h0;
  logic [1:0] h1;
  logic       c;
  logic       cm;

  function automatic logic [1:0] ha(
    input logic x,
    input logic y
  );
    return {x & y, x ^ y};
  endfunction

  // Each stage reads the previous stage register; stage 0 reads the ports.
  always_comb begin
    src[0]   = '{a: a, b: b, s: '0, c: cin, o: 1'b0};
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src[k]   = st_q[k-1];
      src_v[k] = v_q[k-1];
    end
  end

  always_comb begin
    h0 = '0;
    h1 = '0;
    c  = 1'b0;
    cm = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = src[k];
      c       = src[k].c;
      cm      = src[k].c;
      for (int i = 0; i < SLICE; i++) begin
        h0 = ha(src[k].a[k*SLICE+i], src[k].b[k*SLICE+i]);
        h1 = ha(h0[0], c);
        st_d[k].s[k*SLICE+i] = h1[0];
        cm = c;
        c  = h0[1] | h1[1];
      end
      st_d[k].c = c;
      st_d[k].o = cm ^ c;
    end
  end

  // lv[k]: stage k loads this edge; lv[STAGES] is the downstream accept.
  always_comb begin
    lv         = '0;
    lv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      lv[k] = !v_q[k] || lv[k+1];
    end
  end

  assign in_ready = lv[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (lv[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            st_q[k] <= st_d[k];
          end
        end
      end
    end
  end

  assign sum       = st_q[STAGES-1].s;
  assign cout      = st_q[STAGES-1].c;
  assign ovf       = st_q[STAGES-1].o;
  assign out_valid = v_q[STAGES-1];

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined ripple-carry adder. It is the next generation of the team's gate-level half adder: N-bit operands, carry-in, carry-out, signed overflow. The carry chain is split into STAGES register slices with a valid/ready handshake on both sides. It sits between operand-producing datapath logic and downstream accumulators and must sustain one addition per clock under full throughput.

Parameters:
WIDTH, 16, operand and sum width in bits; must be ≥2.
STAGES, 2, number of pipeline register slices; ≥1; WIDTH must be divisible by STAGES (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
a  input  WIDTH  operand A, sampled on input handshake.
b  input  WIDTH  operand B, sampled on input handshake.
cin  input  1  carry-in, sampled on input handshake.
in_valid  input  1  upstream offers a/b/cin.
in_ready  output  1  block accepts this cycle.
sum  output  WIDTH  (a+b+cin) mod 2^WIDTH.
cout  output  1  carry out of the MSB.
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
out_valid  output  1  sum/cout/ovf valid.
out_ready  input  1  downstream accepts this cycle.

Behaviour:
- Reset: synchronous, active-high on rst. On the reset edge, all stage valid bits clear. out_valid=0, sum=0, cout=0, ovf=0. in_ready reads 1 in the first cycle after rst deasserts. Reset mid-operation discards all in-flight results with no partial output.
- Slicing: SLICE=WIDTH/STAGES.
  - Stage k (0..STAGES-1) adds operand bits [k*SLICE +: SLICE] with the carry registered from stage k-1. Stage 0 uses cin.
  - Each slice is a ripple of full adders, each built as two half adders plus an OR.
  - Higher operand bits not yet consumed travel forward in the stage registers. Completed low sum bits travel forward as well.
- Input handshake: a transfer occurs when in_valid && in_ready on a rising edge.
- Output handshake: a transfer occurs when out_valid && out_ready.
- Stage advance rules:
  - Each stage k holds a valid bit v[k].
  - Stage k loads from stage k-1 (or the input for k=0) when !v[k] || adv[k].
  - The final stage satisfies adv when out_ready=1. Stage k<STAGES-1 satisfies adv when stage k+1 loads.
  - in_ready = !v[0] || adv[0]. This is combinational from out_ready through the chain; a registered skid buffer is not required.
- Latency: exactly STAGES cycles from the accepting edge to out_valid=1 when unstalled.
- Throughput: one result per cycle when out_ready held 1.
- Stall: while out_valid=1 && out_ready=0, sum/cout/ovf/out_valid hold stable. Bubbles in earlier stages still compress forward.
- No-drop rule: a transaction is never lost or duplicated. The output order equals the input order.
- Output registers update only on stage load. When the final stage empties without reload, sum/cout/ovf retain their last values; only out_valid drops.
- Simultaneous events:
  - Accept and output on the same edge with a full pipeline is legal and keeps occupancy constant.
  - rst has priority over every handshake.
- Wrap-around: the sum is modulo 2^WIDTH. cout carries the lost bit. ovf=1 only when a and b share a sign bit and sum's sign differs (cin included in the carry chain).
- STAGES=1: a single register after a full-width combinational ripple, latency 1.

Test Plan:
1. WIDTH=16, STAGES=2, out_ready=1: a=0xFFFF, b=0x0001, cin=0 accepted at edge 0 -> at edge 2, out_valid=1, sum=0x0000, cout=1, ovf=0.
2. Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1, ovf=1.
3. Throughput: 8 back-to-back transfers (a=i, b=0x0100*i, cin=i[0]) with out_ready=1 -> in_ready constantly 1; 8 consecutive out_valid cycles starting at edge 2; sums match a+b+cin in order.
4. Backpressure: stream 4 transfers with out_ready=0 -> in_ready falls after 2 accepted (pipeline full); the first result holds stable. Raise out_ready -> results drain in order, none lost or duplicated.
5. Reset mid-flight: 2 transfers in the pipe, assert rst for one cycle -> out_valid=0 next cycle; neither result ever appears; in_ready=1 afterwards.
6. Carry propagation across slices: a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0. The carry crosses the slice 0→1 boundary correctly; repeat with STAGES=4 and STAGES=1 builds.
